hazard_sequencer: RTL

- Pipeline control block for the 5-stage MIPS core.
- Sequences the IF/ID/EX boundaries: stalls the PC and IF/ID register, injects bubbles into ID/EX, and flushes IF on taken branch/jump.
- Covers load-use and branch-in-ID data hazards. Branch compare lives in the decode stage, so branch operands may need 1–2 stall cycles.
- Honors an external hold from memory.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_detect.sv | 53 +++++
 rtl/hazard_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard sequencer.
// States, stall-length constants and the zero-register id.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN,
    STALL,
    HOLD
  } state_t;

  localparam int REG_ZERO = 0;

  localparam int STALL_MAX_DEF = 2;
  typedef logic [$clog2(STALL_MAX_DEF+1)-1:0] stall_cnt_t;

  localparam int LOADUSE_STALL     = 1;
  localparam int LOAD_BRANCH_STALL = 2;
  localparam int ALU_BRANCH_STALL  = 1;
  localparam int MEM_BRANCH_STALL  = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational register-address compare.
// Produces the number of stall cycles the ID instruction needs.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CW         = 2
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_branch,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  input  logic                  mem_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  output logic [CW-1:0]         need
);

  localparam logic [REG_ADDR_W-1:0] ZERO =
    REG_ADDR_W'(REG_ZERO);

  logic ex_hit;
  logic mem_hit;
  int   n_max;

  assign ex_hit =
    (ex_write_reg != ZERO) &&
    ((id_uses_rs && (id_rs == ex_write_reg)) ||
     (id_uses_rt && (id_rt == ex_write_reg)));

  assign mem_hit =
    (mem_write_reg != ZERO) &&
    ((id_uses_rs && (id_rs == mem_write_reg)) ||
     (id_uses_rt && (id_rt == mem_write_reg)));

  // worst case over every hazard source that matches
  always_comb begin
    n_max = 0;
    if (ex_mem_read && ex_hit)
      n_max = max2(n_max, id_branch ?
                   LOAD_BRANCH_STALL : LOADUSE_STALL);
    if (!ex_mem_read && ex_reg_write &&
        ex_hit && id_branch)
      n_max = max2(n_max, ALU_BRANCH_STALL);
    if (mem_mem_read && mem_hit && id_branch)
      n_max = max2(n_max, MEM_BRANCH_STALL);
    need = CW'(n_max);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: front-end stall/bubble/flush sequencing.
// Optional perf counters under HAZARD_PERF_COUNTERS_EN.
module hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MAX_STALL  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  holdInput,
  input  logic [REG_ADDR_W-1:0] idRsInput,
  input  logic [REG_ADDR_W-1:0] idRtInput,
  input  logic                  idUsesRsInput,
  input  logic                  idUsesRtInput,
  input  logic                  idBranchInput,
  input  logic                  branchTakenInput,
  input  logic                  jumpInput,
  input  logic                  exMemReadInput,
  input  logic                  exRegWriteInput,
  input  logic [REG_ADDR_W-1:0] exWriteRegInput,
  input  logic                  memMemReadInput,
  input  logic [REG_ADDR_W-1:0] memWriteRegInput,
  output logic                  pcWriteOutput,
  output logic                  ifIdWriteOutput,
  output logic                  idExBubbleOutput,
  output logic                  ifFlushOutput,
  output logic [31:0]           stallCountOutput,
  output logic [31:0]           flushCountOutput
);

  localparam int CW = $clog2(MAX_STALL+1);

  state_t        state_q;
  state_t        saved_q;
  state_t        eff;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] need;
  logic          pc_we;
  logic          ifid_we;
  logic          bubble;
  logic          flush;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W),
    .CW        (CW)
  ) u_detect (
    .id_rs        (idRsInput),
    .id_rt        (idRtInput),
    .id_uses_rs   (idUsesRsInput),
    .id_uses_rt   (idUsesRtInput),
    .id_branch    (idBranchInput),
    .ex_mem_read  (exMemReadInput),
    .ex_reg_write (exRegWriteInput),
    .ex_write_reg (exWriteRegInput),
    .mem_mem_read (memMemReadInput),
    .mem_write_reg(memWriteRegInput),
    .need         (need)
  );

  // HOLD behaves as the state it interrupted once hold drops
  assign eff = (state_q == HOLD) ? saved_q : state_q;

  // hold beats stall beats flush; stall cycles never flush
  always_comb begin
    pc_we   = 1'b1;
    ifid_we = 1'b1;
    bubble  = 1'b0;
    flush   = 1'b0;
    if (!reset) begin
      pc_we   = 1'b1;
    end else if (holdInput) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (eff == STALL || need != '0) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      bubble  = 1'b1;
    end else begin
      flush = jumpInput |
              (idBranchInput & branchTakenInput);
    end
  end

  // stall sequencing with hold save/resume
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
    end else if (holdInput) begin
      if (state_q != HOLD) begin
        saved_q <= state_q;
        state_q <= HOLD;
      end
    end else begin
      case (eff)
        RUN: begin
          if (need != '0) begin
            cnt_q   <= need - CW'(1);
            state_q <= (need > CW'(1)) ? STALL : RUN;
          end else begin
            state_q <= RUN;
          end
        end
        STALL: begin
          cnt_q   <= cnt_q - CW'(1);
          state_q <= (cnt_q <= CW'(1)) ? RUN : STALL;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pcWriteOutput    = pc_we;
  assign ifIdWriteOutput  = ifid_we;
  assign idExBubbleOutput = bubble;
  assign ifFlushOutput    = flush;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // count bubble and flush cycles, wrapping at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stallCountOutput = stall_cnt_q;
  assign flushCountOutput = flush_cnt_q;
`else
  assign stallCountOutput = '0;
  assign flushCountOutput = '0;
`endif

endmodule
